leitor_teclado: RTL and testbench
=================================

LEITOR_TECLADO -- requirements
Module: leitor_teclado

Interface
REQ-001 Parameter SCAN_CICLOS, default 1000: clock cycles each row stays driven during scan (>=4).
REQ-002 Parameter DEBOUNCE_CICLOS, default 100000: consecutive stable cycles needed to accept a press or a release (>=2).
REQ-003 Parameter REPEAT_CICLOS, default 25000000: held-key repeat period; used only when the repeat macro is defined.
REQ-004 clock  in  1  single system clock; all logic rising-edge.
REQ-005 zera_s  in  1  synchronous, active-high reset.
REQ-006 colunas  in  4  keypad column inputs, pulled up, active-low, asynchronous to clock.
REQ-007 linhas  out  4  row drive, one-cold (1110, 1101, 1011, 0111 = rows 0..3).
REQ-008 tecla  out  4  key code {row[1:0], col[1:0]} of the last accepted key.
REQ-009 valido  out  1  one-cycle pulse marking a new tecla value.
REQ-010 pressionada  out  1  high while an accepted key is held.

Function
REQ-011 colunas SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-012 The FSM SHALL have states VARRE, CONFIRMA, EMITE, SOLTA.
REQ-013 VARRE: each row driven SCAN_CICLOS cycles, rows 0->1->2->3->0 wrap; synchronized columns sampled on the last cycle of each slot.
REQ-014 VARRE: if any sampled column is low, the FSM SHALL capture the column pattern, freeze linhas on that row, clear the debounce counter, and enter CONFIRMA.
REQ-015 Several columns low in one row: the lowest column index SHALL be encoded.
REQ-016 CONFIRMA: a synchronized column value differing from the captured pattern SHALL return to VARRE at the start of the next row; DEBOUNCE_CICLOS consecutive matching cycles SHALL enter EMITE.
REQ-017 EMITE lasts exactly one cycle: tecla updated and valido=1 in that same cycle; pressionada set; then SOLTA.
REQ-018 SOLTA: linhas held; the debounce counter SHALL count consecutive cycles with all synchronized columns high and clear on any low column; at DEBOUNCE_CICLOS, pressionada clears and the FSM enters VARRE at the next row.
REQ-019 tecla SHALL hold its value between valido pulses, including after release.
REQ-020 Keys in other rows SHALL be ignored while in CONFIRMA, EMITE, or SOLTA.
REQ-021 Counters SHALL saturate or clear and never wrap into a false acceptance.

Reset
REQ-022 With zera_s high at a clock edge, the block SHALL set: state VARRE, linhas=1110, tecla=0000, valido=0, pressionada=0, counters=0, synchronizer flops=1111.
REQ-023 zera_s asserted mid-press, in any state, SHALL abort the press with no valido pulse; the first slot after reset is row 0.

Configuration
REQ-024 Macro TECLADO_REPEAT_EN defined: in SOLTA, a repeat counter SHALL pulse valido every REPEAT_CICLOS cycles while the key stays low, with tecla unchanged; the counter clears on entry to SOLTA and on each pulse.
REQ-025 Macro TECLADO_REPEAT_EN undefined: the repeat logic SHALL be absent, and each press SHALL yield exactly one valido.

Structure
REQ-026 A shared package teclado_pkg SHALL hold the state encodings, the row-drive patterns (1110/1101/1011/0111), and the key-code width constant.
REQ-027 The scan-slot timer and the debounce timer SHALL each be an instance of the existing contador_m (M=SCAN_CICLOS / DEBOUNCE_CICLOS, zera_s used as clear); no other sub-module is required.

Verification (SCAN_CICLOS=4, DEBOUNCE_CICLOS=8, REPEAT_CICLOS=40)
REQ-028 Reset, then idle colunas=1111 for 64 cycles -> linhas cycles 1110,1101,1011,0111 every 4 cycles; valido never asserted.
REQ-029 Key row 2/col 1 held clean (colunas=1101 while linhas=1011) -> exactly one valido, tecla=1001, pressionada=1; release for 8 cycles -> pressionada=0, scan resumes at row 3.
REQ-030 Bouncing press (col low 3 cycles, high 1, repeat) for 20 cycles, then stable -> no valido during bounce; a single valido 8 matching cycles after stabilization.
REQ-031 Row 0, columns 0 and 3 low together (colunas=0110) -> tecla=0000.
REQ-032 zera_s pulsed during CONFIRMA -> no valido, outputs at reset values; a later valid press is accepted normally.
REQ-033 With TECLADO_REPEAT_EN, key held 130 cycles past acceptance -> valido at acceptance, then +40, +80, +120 cycles, with tecla constant; without the macro -> a single valido.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared definitions for the 4x4 keypad reader: FSM state encodings,
// one-cold row-drive patterns, key-code width and small decode helpers.
package teclado_pkg;

    localparam int TECLA_W = 4;

    // FSM state encodings
    localparam logic [1:0] VARRE    = 2'd0;
    localparam logic [1:0] CONFIRMA = 2'd1;
    localparam logic [1:0] EMITE    = 2'd2;
    localparam logic [1:0] SOLTA    = 2'd3;

    // Row-drive patterns, one row pulled low at a time
    localparam logic [3:0] LINHA_0 = 4'b1110;
    localparam logic [3:0] LINHA_1 = 4'b1101;
    localparam logic [3:0] LINHA_2 = 4'b1011;
    localparam logic [3:0] LINHA_3 = 4'b0111;

    // Row index -> drive pattern
    function automatic logic [3:0] linha_ativa(input logic [1:0] idx);
        logic [3:0] padrao;
        case (idx)
            2'd0:    padrao = LINHA_0;
            2'd1:    padrao = LINHA_1;
            2'd2:    padrao = LINHA_2;
            default: padrao = LINHA_3;
        endcase
        return padrao;
    endfunction

    // Lowest-index active-low column wins when several are pressed
    function automatic logic [1:0] coluna_baixa(input logic [3:0] col);
        logic [1:0] idx;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M cycle counter. zera_s clears synchronously and has priority over
// conta; fim is high while the count sits at M-1.
module contador_m #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] FIM_V = W'(M - 1);

    logic [W-1:0] valor_q, valor_d;

    // Next count: advance when enabled, wrap after M-1
    always_comb begin
        valor_d = valor_q;
        if (conta) begin
            valor_d = (valor_q == FIM_V) ? '0 : valor_q + W'(1);
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clock) begin
        if (zera_s) valor_q <= '0;
        else        valor_q <= valor_d;
    end

    assign fim = (valor_q == FIM_V);

endmodule

// File: rtl/leitor_teclado.sv
// 4x4 matrix keypad reader: row scan, debounced press/release detection,
// key-code output. Optional held-key auto-repeat is built when the macro
// TECLADO_REPEAT_EN is defined; the default build has no repeat logic.
// valido is a one-cycle strobe with no back-pressure: tecla is valid in the
// same cycle valido is high and holds its value until the next strobe.
// The debug output estado exposes the FSM state register.
module leitor_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_CICLOS     = 1000,
    parameter int DEBOUNCE_CICLOS = 100000,
    parameter int REPEAT_CICLOS   = 25000000
) (
    input  logic               clock,
    input  logic               zera_s,
    input  logic [3:0]         colunas,
    output logic [3:0]         linhas,
    output logic [TECLA_W-1:0] tecla,
    output logic               valido,
    output logic               pressionada,
    output logic [1:0]         estado
);

    logic [3:0]         sinc1_q, sinc2_q;
    logic [1:0]         estado_q, estado_d;
    logic [1:0]         linha_q, linha_d;
    logic [3:0]         captura_q, captura_d;
    logic [TECLA_W-1:0] tecla_q, tecla_d;
    logic               pressionada_q, pressionada_d;
    logic               varre_fim, deb_fim;
    logic               deb_clr, deb_en;
    logic [1:0]         prox_linha;

    assign prox_linha = linha_q + 2'd1;

    // Two-flop synchronizer; idle columns read as all-high
    always_ff @(posedge clock) begin
        if (zera_s) begin
            sinc1_q <= 4'hF;
            sinc2_q <= 4'hF;
        end else begin
            sinc1_q <= colunas;
            sinc2_q <= sinc1_q;
        end
    end

    // Slot timer runs only while scanning, so a return to VARRE starts a full slot
    contador_m #(.M(SCAN_CICLOS)) u_varre (
        .clock  (clock),
        .zera_s (zera_s | (estado_q != VARRE)),
        .conta  (1'b1),
        .fim    (varre_fim)
    );

    // Debounce timer; cleared whenever its run of stable cycles is broken or used
    contador_m #(.M(DEBOUNCE_CICLOS)) u_debounce (
        .clock  (clock),
        .zera_s (zera_s | deb_clr),
        .conta  (deb_en),
        .fim    (deb_fim)
    );

    // Next-state logic for scan, confirm, emit and release tracking
    always_comb begin
        estado_d      = estado_q;
        linha_d       = linha_q;
        captura_d     = captura_q;
        tecla_d       = tecla_q;
        pressionada_d = pressionada_q;
        deb_clr       = 1'b1;
        deb_en        = 1'b0;
        case (estado_q)
            VARRE: begin
                if (varre_fim) begin
                    if (sinc2_q != 4'hF) begin
                        captura_d = sinc2_q;
                        estado_d  = CONFIRMA;
                    end else begin
                        linha_d = prox_linha;
                    end
                end
            end
            CONFIRMA: begin
                if (sinc2_q != captura_q) begin
                    estado_d = VARRE;
                    linha_d  = prox_linha;
                end else if (deb_fim) begin
                    // This cycle is the last of the required matching run
                    estado_d      = EMITE;
                    tecla_d       = {linha_q, coluna_baixa(captura_q)};
                    pressionada_d = 1'b1;
                end else begin
                    deb_clr = 1'b0;
                    deb_en  = 1'b1;
                end
            end
            EMITE: begin
                estado_d = SOLTA;
            end
            SOLTA: begin
                if (sinc2_q == 4'hF) begin
                    if (deb_fim) begin
                        estado_d      = VARRE;
                        linha_d       = prox_linha;
                        pressionada_d = 1'b0;
                    end else begin
                        deb_clr = 1'b0;
                        deb_en  = 1'b1;
                    end
                end
            end
            default: begin
                estado_d = VARRE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (zera_s) begin
            estado_q      <= VARRE;
            linha_q       <= 2'd0;
            captura_q     <= 4'hF;
            tecla_q       <= '0;
            pressionada_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            linha_q       <= linha_d;
            captura_q     <= captura_d;
            tecla_q       <= tecla_d;
            pressionada_q <= pressionada_d;
        end
    end

`ifdef TECLADO_REPEAT_EN
    localparam int REP_W = (REPEAT_CICLOS > 1) ? $clog2(REPEAT_CICLOS) : 1;
    localparam logic [REP_W-1:0] REP_FIM = REP_W'(REPEAT_CICLOS - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_pulso;

    // Repeat timer: counts held cycles in SOLTA, zero elsewhere and after each pulse
    always_comb begin
        rep_d     = '0;
        rep_pulso = 1'b0;
        if (estado_q == SOLTA && sinc2_q != 4'hF) begin
            if (rep_q == REP_FIM) begin
                rep_pulso = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    // Repeat timer register
    always_ff @(posedge clock) begin
        if (zera_s) rep_q <= '0;
        else        rep_q <= rep_d;
    end

    assign valido = (estado_q == EMITE) | rep_pulso;
`else
    logic [31:0] unused_repeat_ciclos;
    assign unused_repeat_ciclos = 32'(REPEAT_CICLOS);
    assign valido = (estado_q == EMITE);
`endif

    assign linhas      = linha_ativa(linha_q);
    assign tecla       = tecla_q;
    assign pressionada = pressionada_q;
    assign estado      = estado_q;

endmodule

// File: tb/tb_leitor_teclado.sv
// Self-checking bench for leitor_teclado with a behavioural keypad model.
// Honours TECLADO_REPEAT_EN the same way as the design.
`timescale 1ns/1ps
module tb_leitor_teclado;
    import teclado_pkg::*;

    localparam int SCAN = 4;
    localparam int DEB  = 8;
    localparam int REP  = 40;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       zera_s = 1'b1;
    logic [3:0] colunas;
    logic [3:0] linhas;
    logic [3:0] tecla;
    logic       valido;
    logic       pressionada;
    logic [1:0] estado;

    always #5 clock = ~clock;

    // keypad model: pressed columns of key_row pull low while that row is driven
    logic       key_down = 1'b0;
    logic [1:0] key_row  = 2'd0;
    logic [3:0] key_cols = 4'b0000;
    assign colunas = (key_down && linhas[key_row] == 1'b0) ? ~key_cols : 4'hF;

    leitor_teclado #(
        .SCAN_CICLOS     (SCAN),
        .DEBOUNCE_CICLOS (DEB),
        .REPEAT_CICLOS   (REP)
    ) dut (
        .clock       (clock),
        .zera_s      (zera_s),
        .colunas     (colunas),
        .linhas      (linhas),
        .tecla       (tecla),
        .valido      (valido),
        .pressionada (pressionada),
        .estado      (estado)
    );

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int         obs_cyc_q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] linhas_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // monitor: record every valido strobe with its cycle number
    always @(posedge clock) begin
        #1;
        cyc++;
        if (valido === 1'b1) begin
            obs_q.push_back(tecla);
            obs_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic passo(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic espera_pressionada(input logic nivel, input int limite,
                                      output int ciclos, output bit ok);
        ciclos = 0;
        ok = 1'b0;
        while (ciclos < limite) begin
            if (pressionada === nivel) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            ciclos++;
        end
    endtask

    task automatic espera_valido(input int limite, output bit ok);
        int c;
        c = 0;
        ok = 1'b0;
        while (c < limite) begin
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            c++;
        end
    endtask

    task automatic limpa_obs();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic solta_e_espera(input string nome);
        int c;
        bit ok;
        key_down = 1'b0;
        espera_pressionada(1'b0, 40, c, ok);
        n_vec++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s_release: pressionada got %b required 0 within 40 cycles", nome, pressionada);
        end
        passo(2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        zera_s = 1'b1;
        key_down = 1'b0;
        passo(3);
        n_vec++; if (linhas !== 4'b1110) begin n_err++; $display("FAIL reset_linhas: got %b required 1110", linhas); end
        n_vec++; if (tecla !== 4'b0000) begin n_err++; $display("FAIL reset_tecla: got %b required 0000", tecla); end
        n_vec++; if (valido !== 1'b0) begin n_err++; $display("FAIL reset_valido: got %b required 0", valido); end
        n_vec++; if (pressionada !== 1'b0) begin n_err++; $display("FAIL reset_pressionada: got %b required 0", pressionada); end
        n_vec++; if (estado !== VARRE) begin n_err++; $display("FAIL reset_estado: got %0d required %0d", estado, VARRE); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_l;
        limpa_obs();
        zera_s = 1'b0;
        for (int k = 0; k < 64; k++) begin
            exp_l = linhas_tab[(k / SCAN) % 4];
            n_vec++;
            if (linhas !== exp_l || valido !== 1'b0) begin
                n_err++;
                $display("FAIL idle_scan k=%0d: linhas=%b valido=%b required linhas=%b valido=0", k, linhas, valido, exp_l);
            end
            passo(1);
        end
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL idle_no_valido: got %0d strobes required 0", obs_q.size()); end
    endtask

    task automatic test_clean_press();
        int c;
        bit ok;
        logic [3:0] e;
        limpa_obs();
        key_row = 2'd2; key_cols = 4'b0010;
        exp_q.push_back(4'b1001);
        key_down = 1'b1;
        espera_pressionada(1'b1, 100, c, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL clean_accept: pressionada got %b required 1", pressionada); end
        passo(20);
        n_vec++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL clean_count: got %0d strobes required 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q[0] !== e) begin n_err++; $display("FAIL clean_code: got %b required %b", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        exp_q.delete();
        n_vec++; if (tecla !== 4'b1001) begin n_err++; $display("FAIL clean_tecla: got %b required 1001", tecla); end
        n_vec++; if (pressionada !== 1'b1) begin n_err++; $display("FAIL clean_held: got %b required 1", pressionada); end
        n_vec++; if (linhas !== 4'b1011) begin n_err++; $display("FAIL clean_row_frozen: got %b required 1011", linhas); end
        // release: 2 sync cycles + DEB consecutive high cycles
        key_down = 1'b0;
        espera_pressionada(1'b0, 40, c, ok);
        n_vec++;
        if (ok !== 1'b1 || c != DEB + 2) begin
            n_err++; $display("FAIL clean_release_time: got %0d cycles (done=%b) required %0d", c, ok, DEB + 2);
        end
        n_vec++; if (linhas !== 4'b0111) begin n_err++; $display("FAIL clean_resume_row3: got %b required 0111", linhas); end
        n_vec++; if (tecla !== 4'b1001) begin n_err++; $display("FAIL clean_tecla_hold: got %b required 1001", tecla); end
        passo(SCAN - 1);
        n_vec++; if (linhas !== 4'b0111) begin n_err++; $display("FAIL clean_row3_slot_end: got %b required 0111", linhas); end
        passo(1);
        n_vec++; if (linhas !== 4'b1110) begin n_err++; $display("FAIL clean_wrap_row0: got %b required 1110", linhas); end
    endtask

    task automatic test_multi_col();
        bit ok;
        logic [3:0] e;
        limpa_obs();
        key_row = 2'd0; key_cols = 4'b1001;
        exp_q.push_back(4'b0000);
        key_down = 1'b1;
        espera_valido(80, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL multi_accept: no valido within 80 cycles"); end
        passo(4);
        n_vec++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL multi_count: got %0d strobes required 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q[0] !== e) begin n_err++; $display("FAIL multi_code: got %b required %b", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        exp_q.delete();
        solta_e_espera("multi");
    endtask

    task automatic test_bounce();
        bit ok;
        int t0;
        int delta;
        logic [3:0] e;
        limpa_obs();
        key_row = 2'd1; key_cols = 4'b0100;
        exp_q.push_back(4'b0110);
        for (int i = 0; i < 20; i++) begin
            key_down = ((i % 4) != 3);
            passo(1);
        end
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL bounce_quiet: got %0d strobes required 0", obs_q.size()); end
        key_down = 1'b1;
        t0 = cyc;
        espera_valido(60, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL bounce_accept: no valido within 60 cycles"); end
        if (ok) begin
            delta = obs_cyc_q[0] - t0;
            n_vec++;
            if (delta < DEB + 2 || delta > 40) begin
                n_err++; $display("FAIL bounce_latency: got %0d cycles required %0d..40", delta, DEB + 2);
            end
        end
        passo(4);
        n_vec++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL bounce_count: got %0d strobes required 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q[0] !== e) begin n_err++; $display("FAIL bounce_code: got %b required %b", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        exp_q.delete();
        solta_e_espera("bounce");
    endtask

    task automatic test_reset_confirma();
        int c;
        bit ok;
        logic [3:0] e;
        limpa_obs();
        key_row = 2'd3; key_cols = 4'b1000;
        key_down = 1'b1;
        c = 0;
        while (c < 60 && estado !== CONFIRMA) begin
            passo(1);
            c++;
        end
        n_vec++; if (estado !== CONFIRMA) begin n_err++; $display("FAIL rstc_reach_confirma: estado got %0d required %0d", estado, CONFIRMA); end
        zera_s = 1'b1;
        key_down = 1'b0;
        passo(1);
        zera_s = 1'b0;
        n_vec++; if (linhas !== 4'b1110) begin n_err++; $display("FAIL rstc_linhas: got %b required 1110", linhas); end
        n_vec++; if (tecla !== 4'b0000) begin n_err++; $display("FAIL rstc_tecla: got %b required 0000", tecla); end
        n_vec++; if (pressionada !== 1'b0) begin n_err++; $display("FAIL rstc_pressionada: got %b required 0", pressionada); end
        n_vec++; if (estado !== VARRE) begin n_err++; $display("FAIL rstc_estado: got %0d required %0d", estado, VARRE); end
        passo(20);
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL rstc_no_valido: got %0d strobes required 0", obs_q.size()); end
        exp_q.push_back(4'b1111);
        key_down = 1'b1;
        espera_pressionada(1'b1, 100, c, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstc_reaccept: pressionada got %b required 1", pressionada); end
        passo(4);
        n_vec++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL rstc_count: got %0d strobes required 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q[0] !== e) begin n_err++; $display("FAIL rstc_code: got %b required %b", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        exp_q.delete();
        solta_e_espera("rstc");
    endtask

    task automatic test_repeat();
        bit ok;
        int t_acc;
        int n_exp;
        logic [3:0] e;
        limpa_obs();
        key_row = 2'd1; key_cols = 4'b0001;
`ifdef TECLADO_REPEAT_EN
        n_exp = 4;
`else
        n_exp = 1;
`endif
        for (int i = 0; i < n_exp; i++) exp_q.push_back(4'b0100);
        key_down = 1'b1;
        espera_valido(80, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL repeat_accept: no valido within 80 cycles"); end
        t_acc = cyc;
        if (ok) t_acc = obs_cyc_q[0];
        passo(130);
        n_vec++; if (pressionada !== 1'b1) begin n_err++; $display("FAIL repeat_held: got %b required 1", pressionada); end
        solta_e_espera("repeat");
        n_vec++;
        if (obs_q.size() != n_exp) begin n_err++; $display("FAIL repeat_count: got %0d strobes required %0d", obs_q.size(), n_exp); end
        for (int i = 0; i < n_exp && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q[0] !== e || obs_cyc_q[0] - t_acc != REP * i) begin
                n_err++;
                $display("FAIL repeat_strobe%0d: got code %b at +%0d required code %b at +%0d",
                         i, obs_q[0], obs_cyc_q[0] - t_acc, e, REP * i);
            end
            void'(obs_q.pop_front());
            void'(obs_cyc_q.pop_front());
        end
        exp_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_multi_col();
        test_bounce();
        test_reset_confirma();
        test_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
